// File: rtl/pe_border_et_pkg.sv
// Shared types and helpers for the border PE.
// Holds the controller state enum and the bit-reverse function.
package pe_border_et_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reverse the low w bits of v; upper result bits are zero.
  function automatic logic [31:0] bit_rev(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = v[i];
    end
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/pe_et_ctrl.sv
// Run controller: FSM, cycle counter, weight sequence, shift latch.
// in: start, abort, et_shift; out: state, cnt, rand_w, shift.
module pe_et_ctrl
  import pe_border_et_pkg::*;
#(
  parameter int IWIDTH = 8,
  parameter int SHW    = $clog2(IWIDTH-1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [SHW-1:0]  et_shift,
  output state_e          state,
  output logic [IWIDTH-2:0] cnt,
  output logic [IWIDTH-2:0] rand_w,
  output logic [SHW-1:0]  shift
);

  localparam int CW   = IWIDTH - 1;
  localparam int SMAX = IWIDTH - 2;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SHW-1:0]  shift_q, shift_d;
  logic [SHW-1:0]  shift_sat;
  logic [CW-1:0]   last;

  assign shift_sat = (int'(et_shift) > SMAX)
                   ? SHW'(SMAX) : et_shift;

  // Last count of a run: 2^(CW-s) - 1.
  assign last = {CW{1'b1}} >> shift_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          shift_d = shift_sat;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign state  = state_q;
  assign cnt    = cnt_q;
  assign shift  = shift_q;
  assign rand_w = CW'(bit_rev(32'(cnt_q), CW));

endmodule

// File: rtl/pe_border_et.sv
// Border PE: temporal-unary MAC with early termination.
// Ports: controls in/out (one-cycle delays), ifm/weight, ofm chain.
module pe_border_et
  import pe_border_et_pkg::*;
#(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 16,
  parameter int SHW    = $clog2(IWIDTH-1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     start_d,
  input  logic [SHW-1:0]           et_shift,
  output logic [SHW-1:0]           et_shift_d,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     en_w,
  input  logic                     clr_w,
  output logic                     en_i_d,
  output logic                     clr_i_d,
  output logic                     en_w_d,
  output logic                     clr_w_d,
  input  logic signed [IWIDTH-1:0] ifm,
  output logic                     ifm_sign_d,
  output logic                     ifm_dff_d,
  input  logic                     wght_sign,
  input  logic [IWIDTH-2:0]        wght_abs,
  output logic                     wght_sign_d,
  output logic [IWIDTH-2:0]        wght_abs_d,
  output logic [IWIDTH-2:0]        randW_d,
  input  logic signed [OWIDTH-1:0] ofm,
  output logic signed [OWIDTH-1:0] ofm_d,
  output logic                     busy,
  output logic                     done
);

  localparam int MW = IWIDTH - 1;

  state_e          state;
  logic [MW-1:0]   cnt, rand_w, cnt_sh;
  logic [SHW-1:0]  shift;
  logic            run, go, abort;
  logic            ib, wb;
  logic            ifm_min;
  logic [IWIDTH-1:0] ifm_neg;
  logic [MW-1:0]   ifm_mag;
  logic signed [OWIDTH-1:0] acc_ext, acc_sc;

  logic            start_dly_q, start_dly_d;
  logic [SHW-1:0]  esh_dly_q, esh_dly_d;
  logic            en_i_dly_q, en_i_dly_d;
  logic            clr_i_dly_q, clr_i_dly_d;
  logic            en_w_dly_q, en_w_dly_d;
  logic            clr_w_dly_q, clr_w_dly_d;
  logic            ifm_sign_q, ifm_sign_d_n;
  logic [MW-1:0]   ifm_abs_q, ifm_abs_d;
  logic            wght_sign_q, wght_sign_d_n;
  logic [MW-1:0]   wght_abs_q, wght_abs_d_n;
  logic            dff_q, dff_d;
  logic [MW-1:0]   randw_q, randw_d;
  logic signed [IWIDTH:0]   acc_q, acc_d;
  logic signed [OWIDTH-1:0] psum_q, psum_d;

  pe_et_ctrl #(
    .IWIDTH (IWIDTH),
    .SHW    (SHW)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .et_shift (et_shift),
    .state    (state),
    .cnt      (cnt),
    .rand_w   (rand_w),
    .shift    (shift)
  );

  assign run   = (state == ST_RUN);
  assign go    = (state == ST_IDLE) & start;
  assign abort = run & clr_i;

  // Most-negative ifm has no positive twin: clamp.
  assign ifm_min = ifm[IWIDTH-1] & ~|ifm[IWIDTH-2:0];
  assign ifm_neg = ~ifm + IWIDTH'(1);
  assign ifm_mag = ifm_min ? {MW{1'b1}}
                 : ifm[IWIDTH-1] ? ifm_neg[MW-1:0]
                 : ifm[MW-1:0];

  assign cnt_sh = cnt << shift;
  assign ib     = (cnt_sh < ifm_abs_q);
  assign wb     = (rand_w < wght_abs_q);

  assign acc_ext = OWIDTH'(acc_q);
  assign acc_sc  = acc_ext <<< shift;

  always_comb begin
    start_dly_d   = start;
    esh_dly_d     = et_shift;
    en_i_dly_d    = en_i;
    clr_i_dly_d   = clr_i;
    en_w_dly_d    = en_w;
    clr_w_dly_d   = clr_w;
    ifm_sign_d_n  = ifm_sign_q;
    ifm_abs_d     = ifm_abs_q;
    wght_sign_d_n = wght_sign_q;
    wght_abs_d_n  = wght_abs_q;
    dff_d         = run & ib;
    randw_d       = randw_q;
    acc_d         = acc_q;
    psum_d        = psum_q;

    if (clr_i) begin
      ifm_sign_d_n = 1'b0;
      ifm_abs_d    = '0;
    end else if (en_i) begin
      ifm_sign_d_n = ifm[IWIDTH-1];
      ifm_abs_d    = ifm_mag;
    end

    // Weight is frozen while a run uses it.
    if (state == ST_IDLE) begin
      if (clr_w) begin
        wght_sign_d_n = 1'b0;
        wght_abs_d_n  = '0;
      end else if (en_w) begin
        wght_sign_d_n = wght_sign;
        wght_abs_d_n  = wght_abs;
      end
    end

    if (run) begin
      randw_d = rand_w;
    end

    if (go || abort) begin
      acc_d = '0;
    end else if (run && ib && wb) begin
      if (ifm_sign_q ^ wght_sign_q) begin
        acc_d = acc_q - (IWIDTH+1)'(1);
      end else begin
        acc_d = acc_q + (IWIDTH+1)'(1);
      end
    end

    if (state == ST_DONE) begin
      psum_d = ofm + acc_sc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_dly_q <= 1'b0;
      esh_dly_q   <= '0;
      en_i_dly_q  <= 1'b0;
      clr_i_dly_q <= 1'b0;
      en_w_dly_q  <= 1'b0;
      clr_w_dly_q <= 1'b0;
      ifm_sign_q  <= 1'b0;
      ifm_abs_q   <= '0;
      wght_sign_q <= 1'b0;
      wght_abs_q  <= '0;
      dff_q       <= 1'b0;
      randw_q     <= '0;
      acc_q       <= '0;
      psum_q      <= '0;
    end else begin
      start_dly_q <= start_dly_d;
      esh_dly_q   <= esh_dly_d;
      en_i_dly_q  <= en_i_dly_d;
      clr_i_dly_q <= clr_i_dly_d;
      en_w_dly_q  <= en_w_dly_d;
      clr_w_dly_q <= clr_w_dly_d;
      ifm_sign_q  <= ifm_sign_d_n;
      ifm_abs_q   <= ifm_abs_d;
      wght_sign_q <= wght_sign_d_n;
      wght_abs_q  <= wght_abs_d_n;
      dff_q       <= dff_d;
      randw_q     <= randw_d;
      acc_q       <= acc_d;
      psum_q      <= psum_d;
    end
  end

  assign start_d     = start_dly_q;
  assign et_shift_d  = esh_dly_q;
  assign en_i_d      = en_i_dly_q;
  assign clr_i_d     = clr_i_dly_q;
  assign en_w_d      = en_w_dly_q;
  assign clr_w_d     = clr_w_dly_q;
  assign ifm_sign_d  = ifm_sign_q;
  assign ifm_dff_d   = dff_q;
  assign wght_sign_d = wght_sign_q;
  assign wght_abs_d  = wght_abs_q;
  assign randW_d     = randw_q;
  assign ofm_d       = psum_q;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_pe_border_et.sv
// Bench for pe_border_et: run-level reference model,
// per-cycle output compare, directed and random runs.
module tb_pe_border_et;

  localparam int IW = 8;
  localparam int OW = 16;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 0, en_i = 0, clr_i = 0;
  logic                 en_w = 0, clr_w = 0, wght_sign = 0;
  logic [SW-1:0]        et_shift = '0;
  logic signed [IW-1:0] ifm = '0;
  logic [IW-2:0]        wght_abs = '0;
  logic signed [OW-1:0] ofm = '0;

  logic                 start_d, en_i_d, clr_i_d, en_w_d, clr_w_d;
  logic [SW-1:0]        et_shift_d;
  logic                 ifm_sign_d, ifm_dff_d, wght_sign_d;
  logic [IW-2:0]        wght_abs_d, randW_d;
  logic signed [OW-1:0] ofm_d;
  logic                 busy, done;

  pe_border_et #(.IWIDTH(IW), .OWIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_d(start_d),
    .et_shift(et_shift), .et_shift_d(et_shift_d),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w),
    .en_i_d(en_i_d), .clr_i_d(clr_i_d),
    .en_w_d(en_w_d), .clr_w_d(clr_w_d),
    .ifm(ifm), .ifm_sign_d(ifm_sign_d), .ifm_dff_d(ifm_dff_d),
    .wght_sign(wght_sign), .wght_abs(wght_abs),
    .wght_sign_d(wght_sign_d), .wght_abs_d(wght_abs_d),
    .randW_d(randW_d), .ofm(ofm), .ofm_d(ofm_d),
    .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int rev7(input int k);
    int r = 0;
    for (int i = 0; i < 7; i++) r |= ((k >> i) & 1) << (6 - i);
    return r;
  endfunction

  // Whole-run result straight from the counting rules.
  function automatic int model_acc(input int ia, input int wa,
                                   input bit neg, input int s);
    int a = 0;
    int len = 1 << (7 - s);
    for (int k = 0; k < len; k++)
      if (((k << s) < ia) && (rev7(k) < wa)) a += neg ? -1 : 1;
    return a;
  endfunction

  int m_phase = 0, m_k = 0, m_s = 0, m_len = 0, m_acc = 0;
  bit m_pending = 0;
  bit e_start_d = 0, e_en_i_d = 0, e_clr_i_d = 0;
  bit e_en_w_d = 0, e_clr_w_d = 0;
  logic [SW-1:0] e_et_shift_d = '0;
  bit e_is = 0, e_ws = 0, e_dff = 0, e_busy = 0, e_done = 0;
  int e_ia = 0, e_wa = 0, e_randw = 0;
  logic signed [OW-1:0] e_ofm_d = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_s = 0; m_acc = 0; m_pending = 0;
      e_start_d = 0; e_en_i_d = 0; e_clr_i_d = 0;
      e_en_w_d = 0; e_clr_w_d = 0; e_et_shift_d = '0;
      e_is = 0; e_ia = 0; e_ws = 0; e_wa = 0; e_dff = 0;
      e_randw = 0; e_ofm_d = '0; e_busy = 0; e_done = 0;
    end else begin
      e_start_d = start; e_et_shift_d = et_shift;
      e_en_i_d = en_i; e_clr_i_d = clr_i;
      e_en_w_d = en_w; e_clr_w_d = clr_w;
      if (m_phase == 0) begin
        if (clr_w) begin e_ws = 0; e_wa = 0; end
        else if (en_w) begin e_ws = wght_sign; e_wa = int'(wght_abs); end
      end
      case (m_phase)
        0: begin
          e_dff = 0;
          if (start) begin
            m_s = (et_shift > 6) ? 6 : int'(et_shift);
            m_len = 1 << (7 - m_s);
            m_k = 0; m_phase = 1; m_pending = 1;
          end
        end
        1: begin
          e_dff = ((m_k << m_s) < e_ia);
          e_randw = rev7(m_k);
          if (clr_i) m_phase = 0;
          else if (m_k == m_len - 1) m_phase = 2;
          m_k++;
        end
        default: begin
          e_dff = 0;
          e_ofm_d = 16'(int'(ofm) + m_acc * (1 << m_s));
          m_phase = 0;
        end
      endcase
      if (clr_i) begin e_is = 0; e_ia = 0; end
      else if (en_i) begin
        e_is = ifm[IW-1];
        e_ia = (ifm == 8'sh80) ? 127
             : (ifm < 0) ? -int'(ifm) : int'(ifm);
      end
      if (m_pending) begin
        m_acc = model_acc(e_ia, e_wa, e_is ^ e_ws, m_s);
        m_pending = 0;
      end
      e_busy = (m_phase != 0);
      e_done = (m_phase == 2);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_on) begin
      chk("start_d", start_d, e_start_d);
      chk("et_shift_d", et_shift_d, e_et_shift_d);
      chk("en_i_d", en_i_d, e_en_i_d);
      chk("clr_i_d", clr_i_d, e_clr_i_d);
      chk("en_w_d", en_w_d, e_en_w_d);
      chk("clr_w_d", clr_w_d, e_clr_w_d);
      chk("ifm_sign_d", ifm_sign_d, e_is);
      chk("ifm_dff_d", ifm_dff_d, e_dff);
      chk("wght_sign_d", wght_sign_d, e_ws);
      chk("wght_abs_d", wght_abs_d, e_wa);
      chk("randW_d", randW_d, e_randw);
      chk("ofm_d", ofm_d, e_ofm_d);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
    end
  end

  task automatic load_regs(input int i, input bit ws, input int wa);
    @(negedge clk);
    ifm = IW'(i); en_i = 1;
    wght_sign = ws; wght_abs = 7'(wa); en_w = 1;
    @(negedge clk);
    en_i = 0; en_w = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic run_pe(input int sh, input int o,
                        input int abort_at, input int restart_at,
                        input bit noise,
                        output int cycles, output int dones);
    bit fin = 0;
    cycles = 0; dones = 0;
    @(negedge clk);
    start = 1; et_shift = SW'(sh); ofm = OW'(o);
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      start = 0; clr_i = 0;
      if (!busy) fin = 1;
      else if (done) dones++;
      else begin
        if (cycles == restart_at) start = 1;
        if (cycles == abort_at) clr_i = 1;
        if (noise) begin
          en_w = 1'($urandom); clr_w = 1'($urandom);
          wght_abs = 7'($urandom); wght_sign = 1'($urandom);
        end
        cycles++;
      end
    end
    en_w = 0; clr_w = 0;
    chk("run_terminates", fin, 1);
  endtask

  function automatic logic [63:0] all_outs();
    return {start_d, et_shift_d, en_i_d, clr_i_d, en_w_d,
            clr_w_d, ifm_sign_d, ifm_dff_d, wght_sign_d,
            wght_abs_d, randW_d, ofm_d, busy, done};
  endfunction

  initial begin
    int c, d, ph;

    chk("model_a", model_acc(64, 64, 0, 0), 32);
    chk("model_b", 64'(model_acc(64, 64, 1, 1)), 64'(-16));
    chk("model_c", model_acc(127, 127, 0, 0), 127);

    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);

    rst_n = 1; start = 1; ofm = 16'sd5; chk_on = 1;
    @(negedge clk);
    chk("first_start_busy", busy, 1);
    start = 0;
    wait_idle();
    chk("empty_run_ofm", ofm_d, 5);

    load_regs(64, 0, 64);
    run_pe(0, 0, -1, -1, 0, c, d);
    chk("r30_ofm", ofm_d, 32);
    chk("r30_len", c, 128);
    chk("r30_done", d, 1);

    load_regs(-64, 0, 64);
    run_pe(1, 100, -1, -1, 0, c, d);
    chk("r31_ofm", ofm_d, 68);
    chk("r31_len", c, 64);

    load_regs(-128, 1, 127);
    run_pe(0, 0, -1, -1, 0, c, d);
    chk("r32_ofm", ofm_d, 127);

    load_regs(64, 0, 64);
    run_pe(0, 0, -1, 10, 0, c, d);
    chk("restart_dones", d, 1);
    chk("restart_len", c, 128);
    chk("restart_ofm", ofm_d, 32);

    run_pe(0, 555, 50, -1, 0, c, d);
    chk("abort_len", c, 51);
    chk("abort_dones", d, 0);
    chk("abort_ofm", ofm_d, 32);
    chk("abort_busy", busy, 0);

    load_regs(64, 0, 64);
    @(negedge clk);
    start = 1; et_shift = 0; ofm = 0;
    @(negedge clk);
    start = 0;
    repeat (20) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("midrun_rst_outs", all_outs(), 0);
    chk("midrun_rst_ofm", ofm_d, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_release_done", done, 0);
    load_regs(64, 0, 64);
    run_pe(0, 0, -1, -1, 0, c, d);
    chk("after_rst_ofm", ofm_d, 32);

    load_regs(64, 0, 64);
    run_pe(0, 0, -1, -1, 1, c, d);
    chk("noise_wabs", wght_abs_d, 64);
    chk("noise_ofm", ofm_d, 32);

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      ph = m_phase;
      start = (ph == 0) ? ($urandom % 4 == 0) : ($urandom % 8 == 0);
      et_shift = SW'($urandom);
      ifm = ($urandom % 8 == 0) ? 8'sh80 : IW'($urandom);
      en_i = (ph != 1) && ($urandom % 3 == 0);
      clr_i = (ph == 1) ? ($urandom % 400 == 0)
                        : ($urandom % 10 == 0);
      en_w = ($urandom % 3 == 0);
      clr_w = ($urandom % 10 == 0);
      wght_sign = 1'($urandom);
      wght_abs = 7'($urandom);
      ofm = OW'($urandom);
    end
    @(negedge clk);
    start = 0; en_i = 0; clr_i = 0; en_w = 0; clr_w = 0;
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_border_et.md
PE_BORDER_ET -- requirements
Module: pe_border_et

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, signed ifm/weight width incl. sign (>=3).
REQ-002 SHALL have parameter OWIDTH, default 16, signed partial-sum width (>= IWIDTH+1).
REQ-003 SHALL have parameter SHW, default $clog2(IWIDTH-1), early-termination shift field width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin one MAC run (IDLE only); start_d  out  1  start delayed one cycle.
REQ-007 et_shift  in  SHW  run-length select, latched at start; et_shift_d  out  SHW  delayed one cycle.
REQ-008 en_i, clr_i, en_w, clr_w  in  1 each  ifm/weight register load/clear; en_i_d, clr_i_d, en_w_d, clr_w_d  out  1 each  delayed one cycle.
REQ-009 ifm  in  IWIDTH signed  input feature; ifm_sign_d  out  1  registered ifm sign; ifm_dff_d  out  1  temporal input bit to east neighbour.
REQ-010 wght_sign  in  1, wght_abs  in  IWIDTH-1  weight; wght_sign_d, wght_abs_d  out  registered weight to south neighbour.
REQ-011 randW_d  out  IWIDTH-1  registered weight-comparison sequence for the column.
REQ-012 ofm  in  OWIDTH signed  north partial sum; ofm_d  out  OWIDTH signed  south partial sum.
REQ-013 busy  out  1  run in progress; done  out  1  one-cycle pulse when ofm_d updated.

Function
REQ-014 Input reg: en_i loads sign and magnitude of ifm; magnitude of most-negative value saturates to 2^(IWIDTH-1)-1; clr_i zeroes; clr_i wins over en_i.
REQ-015 Weight reg: en_w loads wght_sign/wght_abs; clr_w zeroes; clr_w wins; loads permitted only in IDLE (ignored when busy).
REQ-016 Effective shift s = min(et_shift, IWIDTH-2), latched at start; run length L = 2^(IWIDTH-1-s) cycles.
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when cnt==L-1; DONE->IDLE unconditionally after one cycle.
REQ-018 cnt (IWIDTH-1 bits) zeroed on IDLE->RUN, incremented each RUN cycle.
REQ-019 randW = bit-reverse of cnt over IWIDTH-1 bits; randW_d registers it each RUN cycle, holds otherwise.
REQ-020 Input bit ib = ((cnt << s) < ifm_abs); weight bit wb = (randW < wght_abs); product bit = ib & wb; ifm_dff_d <= ib in RUN, 0 otherwise.
REQ-021 Accumulator: signed IWIDTH+1 bits, zeroed on IDLE->RUN; each RUN cycle with product bit=1 adds -1 if ifm_sign^wght_sign else +1.
REQ-022 In DONE: ofm_d <= ofm + (sign-extended acc <<< s), modulo 2^OWIDTH; done=1; ofm_d holds in all other states.
REQ-023 busy=1 in RUN and DONE; start while busy ignored.
REQ-024 clr_i asserted in RUN aborts: next state IDLE, acc cleared, no done pulse, ofm_d unchanged.
REQ-025 All *_d control outputs are pure one-cycle delays independent of FSM state.

Reset
REQ-026 rst_n low asynchronously forces IDLE, cnt, acc, all registers and every output to 0, including mid-run; no done pulse on release.
REQ-027 First start accepted on the first rising edge with rst_n high.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the bit-reverse function.
REQ-029 One sub-module SHALL be used: pe_et_ctrl (FSM, cnt, randW, s latch); registers, comparators, accumulator stay in the top.

Verification
REQ-030 IWIDTH=8,OWIDTH=16: ifm=64, w=+64, s=0, ofm=0 -> done after 128 RUN cycles, ofm_d=32.
REQ-031 ifm=-64, w=+64, et_shift=1, ofm=100 -> run 64 cycles, ofm_d=68.
REQ-032 ifm=-128 (saturated 127), w=-127, s=0, ofm=0 -> ofm_d=127.
REQ-033 start again at RUN cycle 10 -> ignored, single done at cycle 128; clr_i at cycle 50 -> IDLE, no done, ofm_d unchanged.
REQ-034 rst_n low at RUN cycle 20 -> all outputs 0 immediately; new run after release gives REQ-030 result.
REQ-035 en_w/clr_w toggled during RUN -> wght_abs_d unchanged; all *_d controls track inputs with exactly one-cycle delay.
